// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master: bus width defaults and FSM state encoding.
package apb_pkg;

   localparam int APB_ADDRW = 32;
   localparam int APB_DATAW = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_RDCAP  = 3'd3,
      ST_RESP   = 3'd4
   } apb_state_e;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command, response and APB bus signals of the command master, seen from master and slave sides.
interface apb_cmd_master_if #(
   parameter int ADDRW = apb_pkg::APB_ADDRW,
   parameter int DATAW = apb_pkg::APB_DATAW
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_write;
   logic [ADDRW-1:0] cmd_addr;
   logic [DATAW-1:0] cmd_wdata;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_write;
   logic [DATAW-1:0] rsp_rdata;
   logic [ADDRW-1:0] paddr;
   logic             pwrite;
   logic             psel;
   logic             penable;
   logic [DATAW-1:0] pwdata;
   logic [DATAW-1:0] prdata;
   logic             busy;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata,
      output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
      output paddr, pwrite, psel, penable, pwdata, busy
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata,
      input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
      input  paddr, pwrite, psel, penable, pwdata, busy
   );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head and occupancy count.
module apb_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTRW-1:0]  r_wr_ptr;
   logic [PTRW-1:0]  r_rd_ptr;
   logic [CNTW-1:0]  r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_count == CNTW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   // Head is read combinationally so the master can load the APB registers in the pop cycle.
   assign o_data = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/apb_cmd_master.sv
// Queues read/write commands and replays them one at a time as zero-wait-state APB transfers.
module apb_cmd_master import apb_pkg::*; #(
   parameter int ADDRW      = APB_ADDRW,
   parameter int DATAW      = APB_DATAW,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   apb_cmd_master_if.master bus
);
   localparam int ENTW = 1 + ADDRW + DATAW;
   localparam int CNTW = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDRW-1:0] ADDR_ALIGN = {{(ADDRW-2){1'b1}}, 2'b00};

   apb_state_e       r_state;
   apb_state_e       w_state_next;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [CNTW-1:0]  w_count;
   logic [ENTW-1:0]  w_head;
   logic             w_head_write;
   logic [ADDRW-1:0] w_head_addr;
   logic [DATAW-1:0] w_head_wdata;
   logic             w_psel;
   logic             w_penable;
   logic             w_rsp_valid;
   logic [ADDRW-1:0] r_paddr;
   logic             r_pwrite;
   logic [DATAW-1:0] r_pwdata;
   logic             r_rsp_write;
   logic [DATAW-1:0] r_rsp_rdata;

   // Ready comes from the registered count only; a same-cycle pop does not free a slot early.
   assign w_push = bus.cmd_valid && !w_full;
   assign w_pop  = (r_state == ST_IDLE) && !w_empty;

   apb_cmd_fifo #(
      .WIDTH (ENTW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  ({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign {w_head_write, w_head_addr, w_head_wdata} = w_head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (!w_empty) w_state_next = ST_SETUP;
         ST_SETUP:  w_state_next = ST_ACCESS;
         ST_ACCESS: w_state_next = r_pwrite ? ST_RESP : ST_RDCAP;
         ST_RDCAP:  w_state_next = ST_RESP;
         ST_RESP:   if (bus.rsp_ready) w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_psel      = 1'b0;
      w_penable   = 1'b0;
      w_rsp_valid = 1'b0;
      case (r_state)
         ST_SETUP:  w_psel = 1'b1;
         ST_ACCESS: begin
            w_psel    = 1'b1;
            w_penable = 1'b1;
         end
         ST_RESP:   w_rsp_valid = 1'b1;
         default:   ;
      endcase
   end

   // The slave registers prdata on the ACCESS edge, so it is sampled one cycle later in RDCAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_paddr     <= '0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         if (w_pop) begin
            r_paddr  <= w_head_addr & ADDR_ALIGN;
            r_pwrite <= w_head_write;
            r_pwdata <= w_head_wdata;
         end
         if (r_state == ST_ACCESS && r_pwrite) begin
            r_rsp_write <= 1'b1;
            r_rsp_rdata <= '0;
         end
         if (r_state == ST_RDCAP) begin
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= bus.prdata;
         end
      end
   end

   assign bus.cmd_ready = !w_full;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_write = r_rsp_write;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.paddr     = r_paddr;
   assign bus.pwrite    = r_pwrite;
   assign bus.psel      = w_psel;
   assign bus.penable   = w_penable;
   assign bus.pwdata    = r_pwdata;
   assign bus.busy      = (r_state != ST_IDLE) || (w_count != '0);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small registered-read APB memory slave.
module tb_apb_cmd_master;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   cyc;
   logic log_en;

   apb_cmd_master_if #(.ADDRW(32), .DATAW(32)) bus ();

   apb_cmd_master #(
      .ADDRW      (32),
      .DATAW      (32),
      .FIFO_DEPTH (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave: 32 words; unwritten words return a fixed pattern, word 5 (0x14) holds an ID value.
   logic [31:0] mem [32];
   logic [31:0] written;
   logic [4:0]  sidx;
   assign sidx = bus.paddr[6:2];

   function automatic logic [31:0] dflt(input logic [4:0] i);
      return (i == 5'd5) ? 32'h0A9B0024 : {16'hA5A5, 11'd0, i};
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         written <= '0;
      end else if (bus.psel && bus.penable) begin
         if (bus.pwrite) begin
            mem[sidx]     <= bus.pwdata;
            written[sidx] <= 1'b1;
         end else begin
            bus.prdata <= written[sidx] ? mem[sidx] : dflt(sidx);
         end
      end
   end

   int          q_setup[$];
   int          q_access[$];
   logic [31:0] q_saddr[$];
   logic [31:0] q_swdata[$];

   always @(posedge clk) begin
      if (log_en && bus.psel && !bus.penable) begin
         q_setup.push_back(cyc);
         q_saddr.push_back(bus.paddr);
         q_swdata.push_back(bus.pwdata);
      end
      if (log_en && bus.psel && bus.penable) begin
         q_access.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pos();
      @(posedge clk);
      #1;
   endtask

   // Issue one command into an idle master, then take its response; lat counts cycles after accept.
   task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic rw, output logic [31:0] rd, output int lat);
      wait_pos();
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      wait_pos();
      bus.cmd_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.rsp_valid && lat < 20);
      rw = bus.rsp_write;
      rd = bus.rsp_rdata;
      bus.rsp_ready = 1'b1;
      wait_pos();
      bus.rsp_ready = 1'b0;
      $display("cmd w=%0d addr=0x%08h wdata=0x%08h -> rsp_write=%0d rdata=0x%08h lat=%0d",
               w, a, d, rw, rd, lat);
   endtask

   initial begin
      logic        rw;
      logic [31:0] rd;
      int          lat;
      int          t;
      int          n_bad;
      int          n_chk;

      n_checks      = 0;
      n_errors      = 0;
      log_en        = 1'b0;
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_psel", bus.psel, 1'b0);
      chk("rst_penable", bus.penable, 1'b0);
      chk("rst_pwrite", bus.pwrite, 1'b0);
      chk("rst_paddr", bus.paddr, 32'h0);
      chk("rst_pwdata", bus.pwdata, 32'h0);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_write", bus.rsp_write, 1'b0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_busy", bus.busy, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 1'b1);

      // Read 0x14 with cycle-accurate phase checks
      wait_pos();
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h14;
      @(negedge clk);
      chk("rd14_accept", bus.cmd_ready, 1'b1);
      wait_pos();
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("rd14_c1_psel", bus.psel, 1'b0);
      chk("rd14_c1_busy", bus.busy, 1'b1);
      @(negedge clk);
      chk("rd14_c2_setup", {bus.psel, bus.penable}, 2'b10);
      chk("rd14_c2_paddr", bus.paddr, 32'h14);
      chk("rd14_c2_pwrite", bus.pwrite, 1'b0);
      @(negedge clk);
      chk("rd14_c3_access", {bus.psel, bus.penable}, 2'b11);
      @(negedge clk);
      chk("rd14_c4_rdcap", {bus.psel, bus.penable, bus.rsp_valid}, 3'b000);
      @(negedge clk);
      chk("rd14_c5_rsp_valid", bus.rsp_valid, 1'b1);
      chk("rd14_c5_rsp_write", bus.rsp_write, 1'b0);
      chk("rd14_c5_rdata", bus.rsp_rdata, 32'h0A9B0024);
      $display("cmd w=0 addr=0x00000014 -> rsp_valid=%0d rdata=0x%08h", bus.rsp_valid, bus.rsp_rdata);
      bus.rsp_ready = 1'b1;
      wait_pos();
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("rd14_done_valid", bus.rsp_valid, 1'b0);
      chk("rd14_done_busy", bus.busy, 1'b0);

      // Write then read back 0x10
      do_cmd(1'b1, 32'h10, 32'hDEADBEEF, rw, rd, lat);
      chk("wr10_rsp_write", rw, 1'b1);
      chk("wr10_rdata", rd, 32'h0);
      chk("wr10_latency", lat, 4);
      do_cmd(1'b0, 32'h10, 32'h0, rw, rd, lat);
      chk("rd10_rsp_write", rw, 1'b0);
      chk("rd10_rdata", rd, 32'hDEADBEEF);
      chk("rd10_latency", lat, 5);

      // Unaligned address is word-aligned on the bus; APB registers hold afterwards
      do_cmd(1'b1, 32'h0000000F, 32'h12345678, rw, rd, lat);
      @(negedge clk);
      chk("align_paddr", bus.paddr, 32'h0000000C);
      chk("hold_pwdata", bus.pwdata, 32'h12345678);
      chk("hold_pwrite", bus.pwrite, 1'b1);
      do_cmd(1'b0, 32'h0000000C, 32'h0, rw, rd, lat);
      chk("align_readback", rd, 32'h12345678);

      // Stall in RESP, fill the FIFO, fifth push refused
      wait_pos();
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h20;
      bus.cmd_wdata = 32'h11111111;
      wait_pos();
      bus.cmd_valid = 1'b0;
      t = 0;
      while (!bus.rsp_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("full_stall_rsp", bus.rsp_valid, 1'b1);
      n_bad = 0;
      for (int i = 0; i < 5; i++) begin
         wait_pos();
         bus.cmd_valid = 1'b1;
         bus.cmd_write = 1'b1;
         bus.cmd_addr  = 32'h30 + 32'(4 * i);
         bus.cmd_wdata = 32'h100 + 32'(i);
         @(negedge clk);
         $display("push %0d addr=0x%08h cmd_ready=%0d", i, bus.cmd_addr, bus.cmd_ready);
         chk($sformatf("full_ready_%0d", i), bus.cmd_ready, (i < 4) ? 1'b1 : 1'b0);
         if (bus.psel) n_bad++;
      end
      wait_pos();
      bus.cmd_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.psel) n_bad++;
      end
      chk("full_psel_quiet", n_bad, 0);
      chk("full_rsp_held", bus.rsp_valid, 1'b1);
      chk("full_ready_low", bus.cmd_ready, 1'b0);
      chk("full_busy", bus.busy, 1'b1);
      bus.rsp_ready = 1'b1;
      wait_pos();
      @(negedge clk);
      chk("full_idle_psel", bus.psel, 1'b0);
      @(negedge clk);
      chk("full_next_setup", {bus.psel, bus.penable}, 2'b10);
      chk("full_next_paddr", bus.paddr, 32'h30);
      t = 0;
      while (bus.busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("full_drained", bus.busy, 1'b0);
      bus.rsp_ready = 1'b0;
      do_cmd(1'b0, 32'h3C, 32'h0, rw, rd, lat);
      chk("full_rd_4th", rd, 32'h00000103);
      do_cmd(1'b0, 32'h40, 32'h0, rw, rd, lat);
      chk("full_rd_5th_absent", rd, 32'hA5A50010);

      // Eight back-to-back writes with rsp_ready held high
      log_en        = 1'b1;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_pos();
         bus.cmd_valid = 1'b1;
         bus.cmd_write = 1'b1;
         bus.cmd_addr  = 32'h40 + 32'(4 * i);
         bus.cmd_wdata = 32'hC0DE0000 + 32'(i);
         t = 0;
         @(negedge clk);
         while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      wait_pos();
      bus.cmd_valid = 1'b0;
      t = 0;
      while (bus.busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("b2b_drained", bus.busy, 1'b0);
      log_en        = 1'b0;
      bus.rsp_ready = 1'b0;
      chk("b2b_nsetup", q_setup.size(), 8);
      chk("b2b_naccess", q_access.size(), 8);
      n_chk = (q_setup.size() < q_access.size()) ? q_setup.size() : q_access.size();
      if (n_chk > 8) n_chk = 8;
      for (int i = 0; i < n_chk; i++) begin
         $display("xfer %0d setup@%0d access@%0d paddr=0x%08h pwdata=0x%08h",
                  i, q_setup[i], q_access[i], q_saddr[i], q_swdata[i]);
         chk($sformatf("b2b_access_follows_%0d", i), q_access[i] - q_setup[i], 1);
         chk($sformatf("b2b_paddr_%0d", i), q_saddr[i], 32'h40 + 32'(4 * i));
         chk($sformatf("b2b_pwdata_%0d", i), q_swdata[i], 32'hC0DE0000 + 32'(i));
         if (i > 0) chk($sformatf("b2b_period_%0d", i), q_setup[i] - q_setup[i-1], 4);
      end
      do_cmd(1'b0, 32'h40, 32'h0, rw, rd, lat);
      chk("b2b_rd_first", rd, 32'hC0DE0000);
      do_cmd(1'b0, 32'h5C, 32'h0, rw, rd, lat);
      chk("b2b_rd_last", rd, 32'hC0DE0007);

      // Reset during ACCESS of a read with two commands queued
      wait_pos();
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h14;
      wait_pos();
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h60;
      bus.cmd_wdata = 32'h1;
      wait_pos();
      bus.cmd_addr  = 32'h64;
      bus.cmd_wdata = 32'h2;
      wait_pos();
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("arst_in_access", {bus.psel, bus.penable, bus.pwrite}, 3'b110);
      #1 rst_n = 1'b0;
      #1;
      $display("async reset asserted: psel=%0d penable=%0d busy=%0d", bus.psel, bus.penable, bus.busy);
      chk("arst_psel_penable", {bus.psel, bus.penable}, 2'b00);
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("arst_paddr", bus.paddr, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      n_bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.rsp_valid || bus.psel) n_bad++;
      end
      chk("arst_no_activity", n_bad, 0);
      chk("arst_busy_after", bus.busy, 1'b0);
      chk("arst_ready_after", bus.cmd_ready, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
